serial_pe_seq: RTL and testbench

- Sequencer that drives one serial_pe through a batch of dot products, replacing hand-timed stimulus.
- Per output: fetches a line-count instruction, streams matching weight/neuron addresses, generates pe_ctl/pe_vld_i aligned to memory read data, waits for pe_vld_o, then writes the result to a result buffer.
- Sits between the instruction/weight/neuron SRAMs (shared read address, 1-cycle read latency) and serial_pe.

---
 rtl/serial_pe_seq_pkg.sv | 24 ++
 rtl/serial_pe_seq_agen.sv | 58 +++++
 rtl/serial_pe_seq.sv | 179 +++++++++++++++++
 tb/tb_serial_pe_seq.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pe_seq_pkg.sv
// serial_pe_seq_pkg: shared types and default widths for the serial_pe sequencer.
package serial_pe_seq_pkg;

    localparam int NUM_OUT_D    = 4;
    localparam int ADDR_W_D     = 9;
    localparam int LINE_ELEMS_D = 32;
    localparam int LEN_W_D      = 8;
    localparam int TIMEOUT_D    = 64;

    localparam logic [1:0] PE_CTL_FIRST = 2'b01;
    localparam logic [1:0] PE_CTL_MID   = 2'b00;
    localparam logic [1:0] PE_CTL_LAST  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LEN,
        S_RUN,
        S_DRAIN,
        S_WRITE,
        S_FIN
    } state_t;

endpackage

// File: rtl/serial_pe_seq_agen.sv
// serial_pe_seq_agen: element address generator. Keeps the running base of the
// batch, the per-output issue counter and total, and flags the first/last issue.
module serial_pe_seq_agen #(
    parameter int ADDR_W     = 9,
    parameter int LINE_ELEMS = 32,
    parameter int LEN_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [LEN_W-1:0]  len,
    input  logic              run,
    input  logic              adv,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              first,
    output logic              last,
    output logic              ovf
);
    localparam int SH    = $clog2(LINE_ELEMS);
    localparam int TOT_W = LEN_W + SH;
    localparam int CHK_W = ((TOT_W > ADDR_W + 1) ? TOT_W : ADDR_W + 1) + 1;

    logic [ADDR_W:0]  base;
    logic [TOT_W-1:0] cnt;
    logic [TOT_W-1:0] total;
    logic [TOT_W-1:0] len_tot;

    assign len_tot = TOT_W'(len) << SH;

    // Requested span must end at or before the top of the element space.
    assign ovf = (CHK_W'(base) + CHK_W'(len_tot)) > CHK_W'(2 ** ADDR_W);

    assign first    = run && (cnt == '0);
    assign last     = run && (cnt == total - TOT_W'(1));
    assign mem_addr = run ? (ADDR_W'(base) + ADDR_W'(cnt)) : '0;

    // Base moves on by one output's span per written result; cleared per batch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   base <= '0;
        else if (clr) base <= '0;
        else if (adv) base <= base + (ADDR_W + 1)'(total);
    end

    // Issue counter restarts when a new line count is latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            total <= '0;
        end else if (load) begin
            cnt   <= '0;
            total <= len_tot;
        end else if (run) begin
            cnt   <= cnt + TOT_W'(1);
        end
    end

endmodule

// File: rtl/serial_pe_seq.sv
// serial_pe_seq: walks a batch of NUM_OUT dot products through one serial_pe.
// Optional DRAIN watchdog enabled by defining SERIAL_PE_SEQ_TIMEOUT_EN.
module serial_pe_seq
    import serial_pe_seq_pkg::*;
#(
    parameter int NUM_OUT    = NUM_OUT_D,
    parameter int ADDR_W     = ADDR_W_D,
    parameter int LINE_ELEMS = LINE_ELEMS_D,
    parameter int LEN_W      = LEN_W_D
`ifdef SERIAL_PE_SEQ_TIMEOUT_EN
   ,parameter int TIMEOUT    = TIMEOUT_D
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       inst_rd,
    output logic [$clog2(NUM_OUT)-1:0] inst_addr,
    input  logic [LEN_W-1:0]           inst_data,
    output logic                       mem_rd,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [1:0]                 pe_ctl,
    output logic                       pe_vld_i,
    input  logic [31:0]                pe_result,
    input  logic                       pe_vld_o,
    output logic                       res_wr,
    output logic [$clog2(NUM_OUT)-1:0] res_addr,
    output logic [31:0]                res_data
);
    localparam int IDX_W = $clog2(NUM_OUT);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] out_idx;
    logic [31:0]      res_q;
    logic             accept, load, adv, set_err, cap, zero_res, run;
    logic             first, last, ovf;
`ifdef SERIAL_PE_SEQ_TIMEOUT_EN
    logic [7:0]       wdog;
`endif

    serial_pe_seq_agen #(
        .ADDR_W     (ADDR_W),
        .LINE_ELEMS (LINE_ELEMS),
        .LEN_W      (LEN_W)
    ) u_agen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept),
        .load     (load),
        .len      (inst_data),
        .run      (run),
        .adv      (adv),
        .mem_addr (mem_addr),
        .first    (first),
        .last     (last),
        .ovf      (ovf)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state plus all strobes; outputs are decoded from state so reset zeroes them at once.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load      = 1'b0;
        adv       = 1'b0;
        set_err   = 1'b0;
        cap       = 1'b0;
        zero_res  = 1'b0;
        run       = 1'b0;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        inst_rd   = 1'b0;
        inst_addr = '0;
        mem_rd    = 1'b0;
        res_wr    = 1'b0;
        res_addr  = '0;
        res_data  = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                inst_rd   = 1'b1;
                inst_addr = out_idx;
                state_nxt = S_LEN;
            end
            S_LEN: begin
                load = 1'b1;
                if (inst_data == '0) begin
                    set_err   = 1'b1;
                    zero_res  = 1'b1;
                    state_nxt = S_WRITE;
                end else if (ovf) begin
                    set_err   = 1'b1;
                    state_nxt = S_FIN;
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                run    = 1'b1;
                mem_rd = 1'b1;
                if (last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (pe_vld_o) begin
                    cap       = 1'b1;
                    state_nxt = S_WRITE;
                end
`ifdef SERIAL_PE_SEQ_TIMEOUT_EN
                else if (wdog == 8'(TIMEOUT - 1)) begin
                    set_err   = 1'b1;
                    state_nxt = S_FIN;
                end
`endif
            end
            S_WRITE: begin
                res_wr    = 1'b1;
                res_addr  = out_idx;
                res_data  = res_q;
                adv       = 1'b1;
                state_nxt = (out_idx == IDX_W'(NUM_OUT - 1)) ? S_FIN : S_FETCH;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output index, captured result and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx <= '0;
            res_q   <= '0;
            err     <= 1'b0;
        end else begin
            if (accept)      out_idx <= '0;
            else if (adv)    out_idx <= out_idx + IDX_W'(1);
            if (cap)         res_q <= pe_result;
            else if (zero_res) res_q <= '0;
            if (accept)      err <= 1'b0;
            else if (set_err) err <= 1'b1;
        end
    end

    // Delay issue-cycle controls by the SRAM read latency so they meet the read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_vld_i <= 1'b0;
            pe_ctl   <= PE_CTL_MID;
        end else begin
            pe_vld_i <= run;
            pe_ctl   <= first ? PE_CTL_FIRST : (last ? PE_CTL_LAST : PE_CTL_MID);
        end
    end

`ifdef SERIAL_PE_SEQ_TIMEOUT_EN
    // Watchdog counts consecutive DRAIN cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                wdog <= '0;
        else if (state == S_DRAIN) wdog <= wdog + 8'd1;
        else                       wdog <= '0;
    end
`endif

endmodule

// File: tb/tb_serial_pe_seq.sv
// tb_serial_pe_seq: randomized batches against an arithmetic reference model;
// the bench also plays the instruction/weight/neuron SRAMs and a serial_pe.
module tb_serial_pe_seq;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err, inst_rd, mem_rd, pe_vld_i, res_wr;
    logic [1:0]  inst_addr, res_addr, pe_ctl;
    logic [7:0]  inst_data;
    logic [8:0]  mem_addr;
    logic [31:0] pe_result, res_data;
    logic        pe_vld_o;

    always #5 clk = ~clk;

    serial_pe_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .inst_rd(inst_rd), .inst_addr(inst_addr), .inst_data(inst_data),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .pe_ctl(pe_ctl), .pe_vld_i(pe_vld_i),
        .pe_result(pe_result), .pe_vld_o(pe_vld_o),
        .res_wr(res_wr), .res_addr(res_addr), .res_data(res_data)
    );

    wire [53:0] all_outs = {busy, done, err, inst_rd, inst_addr, mem_rd, mem_addr,
                            pe_ctl, pe_vld_i, res_wr, res_addr, res_data};

    // SRAMs with one cycle of read latency.
    logic [7:0]  imem [4];
    logic [15:0] wmem [512];
    logic [15:0] nmem [512];
    logic [15:0] w_q, n_q;
    always @(posedge clk) begin
        if (inst_rd) inst_data <= imem[inst_addr];
        if (mem_rd) begin
            w_q <= wmem[mem_addr];
            n_q <= nmem[mem_addr];
        end
    end

    // serial_pe stand-in: multiply-accumulate framed by pe_ctl, result after pe_lat cycles.
    int          pe_lat = 3;
    bit          pe_mute = 1'b0;
    int          pend;
    logic [31:0] acc, pend_val, prod, acc_n;
    assign prod  = {16'd0, w_q} * {16'd0, n_q};
    assign acc_n = (pe_ctl == 2'b01) ? prod : acc + prod;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= 0;
            pe_vld_o <= 1'b0;
            acc      <= '0;
        end else begin
            pe_vld_o  <= 1'b0;
            pe_result <= $urandom;
            if (pend == 1 && !pe_mute) begin
                pe_vld_o  <= 1'b1;
                pe_result <= pend_val;
            end
            if (pend > 0) pend <= pend - 1;
            if (pe_vld_i) begin
                acc <= acc_n;
                if (pe_ctl == 2'b10) begin
                    pend_val <= acc_n;
                    pend     <= pe_lat;
                end
            end
        end
    end

    // Observation log, sampled on the falling edge.
    logic [8:0]  addr_q [$];
    int          run_q [$];
    int          gap_q [$];
    logic [33:0] res_q [$];
    int          done_cnt = 0, cyc = 0, last_rd = 0, done_cyc = 0, run_len = 0, gap = 0;
    bit          prev_vld = 1'b0, seen_run = 1'b0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd) begin
            addr_q.push_back(mem_addr);
            last_rd <= cyc;
        end
        if (pe_vld_i) begin
            if (!prev_vld && seen_run) gap_q.push_back(gap);
            run_len <= prev_vld ? run_len + 1 : 1;
        end else if (prev_vld) begin
            run_q.push_back(run_len);
            seen_run <= 1'b1;
            gap      <= 1;
        end else begin
            gap <= gap + 1;
        end
        prev_vld <= pe_vld_i;
        if (res_wr) res_q.push_back({res_addr, res_data});
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic load_inst(input int a, input int b, input int c, input int d);
        imem[0] = 8'(a); imem[1] = 8'(b); imem[2] = 8'(c); imem[3] = 8'(d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (all_outs !== '0) begin
            n_fail++; $display("FAIL reset_outs: got %h want 0", all_outs);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (all_outs !== '0) begin
            n_fail++; $display("FAIL idle_outs: got %h want 0", all_outs);
        end
    endtask

    // One full batch using imem, checked against the reference walk of the instruction list.
    task automatic test_batch(input string name);
        logic [8:0]  exp_addr [$];
        int          exp_run [$];
        logic [33:0] exp_res [$];
        logic [31:0] sum;
        int          base, tot, a0, r0, g0, s0, d0, nbad;
        bit          exp_err, ok;
        for (int i = 0; i < 512; i++) begin
            wmem[i] = 16'($urandom);
            nmem[i] = 16'($urandom);
        end
        pe_lat  = $urandom_range(1, 6);
        base    = 0;
        exp_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tot = int'(imem[i]) * 32;
            if (tot == 0) begin
                exp_err = 1'b1;
                exp_res.push_back({2'(i), 32'd0});
                continue;
            end
            if (base + tot > 512) begin
                exp_err = 1'b1;
                break;
            end
            sum = 0;
            for (int a = base; a < base + tot; a++) begin
                exp_addr.push_back(9'(a));
                sum += 32'(wmem[a]) * 32'(nmem[a]);
            end
            exp_run.push_back(tot);
            exp_res.push_back({2'(i), sum});
            base += tot;
        end
        a0 = addr_q.size(); r0 = run_q.size(); g0 = gap_q.size();
        s0 = res_q.size();  d0 = done_cnt;

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL %s accept: busy=%b err=%b want busy=1 err=0", name, busy, err);
        end
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (done === 1'b1) ok = 1'b1;
        end
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL %s done_wait: no done within 3000 cycles", name);
            return;
        end
        repeat (3) @(negedge clk);

        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL %s busy_after: got %b want 0", name, busy);
        end
        n_tests++;
        if (err !== exp_err) begin
            n_fail++; $display("FAIL %s err: got %b want %b", name, err, exp_err);
        end
        n_tests++;
        if (done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL %s done_count: got %0d want 1", name, done_cnt - d0);
        end
        nbad = 0;
        if (addr_q.size() - a0 == exp_addr.size())
            foreach (exp_addr[k]) if (addr_q[a0 + k] !== exp_addr[k]) nbad++;
        n_tests++;
        if (addr_q.size() - a0 != exp_addr.size() || nbad != 0) begin
            n_fail++; $display("FAIL %s mem_addr: got %0d reads (%0d wrong) want %0d reads",
                               name, addr_q.size() - a0, nbad, exp_addr.size());
        end
        nbad = 0;
        if (run_q.size() - r0 == exp_run.size())
            foreach (exp_run[k]) if (run_q[r0 + k] != exp_run[k]) nbad++;
        n_tests++;
        if (run_q.size() - r0 != exp_run.size() || nbad != 0) begin
            n_fail++; $display("FAIL %s vld_runs: got %0d runs (%0d wrong) want %0d runs",
                               name, run_q.size() - r0, nbad, exp_run.size());
        end
        nbad = 0;
        for (int k = g0; k < gap_q.size(); k++) if (gap_q[k] < 3) nbad++;
        n_tests++;
        if (nbad != 0) begin
            n_fail++; $display("FAIL %s vld_gap: got %0d gaps under 3 want 0", name, nbad);
        end
        nbad = 0;
        if (res_q.size() - s0 == exp_res.size())
            foreach (exp_res[k]) if (res_q[s0 + k] !== exp_res[k]) nbad++;
        n_tests++;
        if (res_q.size() - s0 != exp_res.size() || nbad != 0) begin
            n_fail++; $display("FAIL %s results: got %0d writes (%0d wrong) want %0d writes",
                               name, res_q.size() - s0, nbad, exp_res.size());
        end
    endtask

    // Re-pulse start mid-RUN, then reset mid-DRAIN.
    task automatic test_restart_reset();
        int a0, d0, nbad;
        bit ok;
        load_inst(4, 4, 4, 4);
        pe_mute = 1'b1;
        a0 = addr_q.size(); d0 = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (mem_rd && mem_addr == 9'd40) ok = 1'b1;
        end
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 500 && mem_rd; c++) @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (!ok || busy !== 1'b1 || err !== 1'b0 || done_cnt != d0) begin
            n_fail++; $display("FAIL restart_drain: busy=%b err=%b dones=%0d want busy=1 err=0 dones=0",
                               busy, err, done_cnt - d0);
        end
        nbad = 0;
        if (addr_q.size() - a0 == 128)
            for (int k = 0; k < 128; k++) if (addr_q[a0 + k] !== 9'(k)) nbad++;
        n_tests++;
        if (addr_q.size() - a0 != 128 || nbad != 0) begin
            n_fail++; $display("FAIL restart_addr: got %0d reads (%0d wrong) want 128 reads 0..127",
                               addr_q.size() - a0, nbad);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (all_outs !== '0) begin
            n_fail++; $display("FAIL async_reset: got %h want 0", all_outs);
        end
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        pe_mute = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (done_cnt != d0 || all_outs !== '0) begin
            n_fail++; $display("FAIL reset_no_done: dones=%0d outs=%h want 0 and 0", done_cnt - d0, all_outs);
        end
    endtask

    // PE never answers: watchdog abort when built with it, otherwise a permanent wait.
    task automatic test_timeout();
        int d0, s0;
        bit ok;
        load_inst(1, 1, 1, 1);
        pe_mute = 1'b1;
        d0 = done_cnt; s0 = res_q.size();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
`ifdef SERIAL_PE_SEQ_TIMEOUT_EN
        ok = 1'b0;
        for (int c = 0; c < 1000 && !ok; c++) begin
            @(negedge clk);
            if (done === 1'b1) ok = 1'b1;
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (!ok || err !== 1'b1 || done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL timeout_abort: done_seen=%b err=%b dones=%0d want 1 1 1",
                               ok, err, done_cnt - d0);
        end
        n_tests++;
        if (res_q.size() != s0) begin
            n_fail++; $display("FAIL timeout_no_write: got %0d writes want 0", res_q.size() - s0);
        end
        n_tests++;
        if (done_cyc - last_rd != TIMEOUT + 1) begin
            n_fail++; $display("FAIL timeout_len: got %0d cycles want %0d", done_cyc - last_rd, TIMEOUT + 1);
        end
`else
        ok = 1'b1;
        repeat (300) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || done_cnt != d0 || res_q.size() != s0) begin
            n_fail++; $display("FAIL drain_wait: busy=%b dones=%0d writes=%0d want 1 0 0",
                               busy, done_cnt - d0, res_q.size() - s0);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (!ok || busy !== 1'b0) begin
            n_fail++; $display("FAIL drain_recover: busy=%b want 0", busy);
        end
`endif
        pe_mute = 1'b0;
    endtask

    initial begin
        test_reset();
        load_inst(4, 4, 4, 4); test_batch("std");
        load_inst(1, 2, 0, 3); test_batch("zero_len");
        load_inst(8, 8, 4, 4); test_batch("overflow");
        test_restart_reset();
        load_inst(4, 4, 4, 4); test_batch("after_reset");
        for (int t = 0; t < 4; t++) begin
            load_inst($urandom_range(0, 5), $urandom_range(0, 5),
                      $urandom_range(0, 5), $urandom_range(0, 5));
            test_batch("random");
        end
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
